hazard_controller: RTL and testbench

Pipeline sequencing controller for the fetch/decode/execute core. It owns the stall, flush and clock-enable lines that drive the fetch/decoder/register-file front end. It also converts execute-stage redirects into a one-cycle PC load, inserts load-use bubbles, holds the pipe while a multi-cycle ALU operation is busy, and runs a start/halt/drain sequence. All outputs are registered (Moore), and a saturating bubble counter is provided for performance debug.

---
 rtl/hazard_controller.sv | 163 ++++++++++++++++
 tb/tb_hazard_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: owns front-end ce/stall/flush, turns redirects
// into a one-cycle PC load, inserts load-use bubbles and runs start/halt/drain.
module hazard_controller #(
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_BUBBLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 hz_clk,
  input  logic                 hz_rst,
  input  logic                 hz_i_start,
  input  logic                 hz_i_halt,
  input  logic                 hz_i_change_pc,
  input  logic [PC_WIDTH-1:0]  hz_i_next_pc,
  input  logic                 hz_i_stall_alu,
  input  logic                 hz_i_ds_valid,
  input  logic                 hz_i_ds_is_load,
  input  logic [AWIDTH-1:0]    hz_i_ds_addr_rd,
  input  logic [AWIDTH-1:0]    hz_i_fi_addr_rs1,
  input  logic [AWIDTH-1:0]    hz_i_fi_addr_rs2,
  input  logic                 hz_i_fi_uses_rs2,
  output logic                 hz_o_ce,
  output logic                 hz_o_stall,
  output logic                 hz_o_flush,
  output logic                 hz_o_pc_load,
  output logic [PC_WIDTH-1:0]  hz_o_pc,
  output logic [2:0]           hz_o_state,
  output logic [CNT_WIDTH-1:0] hz_o_bubble_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_LOAD_STALL = 3'd2,
    ST_ALU_WAIT   = 3'd3,
    ST_FLUSH      = 3'd4,
    ST_DRAIN      = 3'd5,
    ST_HALTED     = 3'd6
  } state_t;

  localparam int SEQW = 16;

  state_t                state_r, state_s;
  logic [SEQW-1:0]       seq_r, seq_s;
  logic [PC_WIDTH-1:0]   pc_r, pc_s;
  logic                  pc_load_r, pc_load_s;
  logic                  ce_r, ce_s, stall_r, stall_s, flush_r, flush_s;
  logic [CNT_WIDTH-1:0]  bub_r;
  logic                  hazard_s;

  // load-use detection between the decode-stage load and the fetched instruction
  always_comb begin
    hazard_s = hz_i_ds_valid & hz_i_ds_is_load &
               (hz_i_ds_addr_rd != {AWIDTH{1'b0}}) &
               ((hz_i_ds_addr_rd == hz_i_fi_addr_rs1) |
                (hz_i_fi_uses_rs2 & (hz_i_ds_addr_rd == hz_i_fi_addr_rs2)));
  end

  // next-state, sequence counter and redirect capture
  always_comb begin
    state_s   = state_r;
    seq_s     = seq_r;
    pc_s      = pc_r;
    pc_load_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (hz_i_start) state_s = ST_RUN;
        else            state_s = state_r;
      end
      ST_RUN, ST_LOAD_STALL, ST_FLUSH: begin
        if (hz_i_stall_alu) begin
          state_s = ST_ALU_WAIT;
        end else if (hz_i_change_pc) begin
          state_s   = ST_FLUSH;
          pc_s      = hz_i_next_pc;
          pc_load_s = 1'b1;
          seq_s     = SEQW'(FLUSH_CYCLES);
        end else if ((state_r == ST_RUN) && hazard_s) begin
          state_s = ST_LOAD_STALL;
          seq_s   = SEQW'(LOAD_BUBBLES);
        end else if ((state_r == ST_RUN) && hz_i_halt) begin
          state_s = ST_DRAIN;
          seq_s   = SEQW'(DRAIN_CYCLES);
        end else if (state_r != ST_RUN) begin
          // the count includes the current cycle, so expire at one
          if (seq_r <= SEQW'(1)) state_s = ST_RUN;
          else                   seq_s   = seq_r - SEQW'(1);
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_ALU_WAIT: begin
        if (hz_i_stall_alu) state_s = ST_ALU_WAIT;
        else                state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (seq_r <= SEQW'(1)) state_s = ST_HALTED;
        else                   seq_s   = seq_r - SEQW'(1);
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Moore output decode of the next state, registered below
  always_comb begin
    ce_s    = 1'b0;
    stall_s = 1'b0;
    flush_s = 1'b0;
    case (state_s)
      ST_RUN:        ce_s = 1'b1;
      ST_LOAD_STALL: begin ce_s = 1'b1; stall_s = 1'b1; end
      ST_ALU_WAIT:   begin ce_s = 1'b1; stall_s = 1'b1; end
      ST_FLUSH:      begin ce_s = 1'b1; flush_s = 1'b1; end
      default:       ce_s = 1'b0;
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge hz_clk or negedge hz_rst) begin
    if (!hz_rst) begin
      state_r   <= ST_IDLE;
      seq_r     <= {SEQW{1'b0}};
      pc_r      <= {PC_WIDTH{1'b0}};
      pc_load_r <= 1'b0;
      ce_r      <= 1'b0;
      stall_r   <= 1'b0;
      flush_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      seq_r     <= seq_s;
      pc_r      <= pc_s;
      pc_load_r <= pc_load_s;
      ce_r      <= ce_s;
      stall_r   <= stall_s;
      flush_r   <= flush_s;
    end
  end

  // saturating count of bubble cycles, cleared on start
  always_ff @(posedge hz_clk or negedge hz_rst) begin
    if (!hz_rst) begin
      bub_r <= {CNT_WIDTH{1'b0}};
    end else if (((state_r == ST_IDLE) || (state_r == ST_HALTED)) && hz_i_start) begin
      bub_r <= {CNT_WIDTH{1'b0}};
    end else if (((state_r == ST_LOAD_STALL) || (state_r == ST_ALU_WAIT) ||
                  (state_r == ST_FLUSH)) && (bub_r != {CNT_WIDTH{1'b1}})) begin
      bub_r <= bub_r + CNT_WIDTH'(1);
    end else begin
      bub_r <= bub_r;
    end
  end

  assign hz_o_ce         = ce_r;
  assign hz_o_stall      = stall_r;
  assign hz_o_flush      = flush_r;
  assign hz_o_pc_load    = pc_load_r;
  assign hz_o_pc         = pc_r;
  assign hz_o_state      = state_r;
  assign hz_o_bubble_cnt = bub_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed per-cycle vectors push expected
// outputs; a monitor pops and compares one entry after every rising edge.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, cpc, salu, dsv, dld, u2;
  logic [31:0] npc;
  logic [4:0]  rd, rs1, rs2;
  logic        ce, stall, flush, pcl;
  logic [31:0] pc;
  logic [2:0]  st;
  logic [3:0]  bub;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  st;
    logic        pcl;
    logic [31:0] pc;
    logic [3:0]  bub;
  } exp_t;
  exp_t q[$];

  hazard_controller #(
    .AWIDTH(5), .PC_WIDTH(32), .FLUSH_CYCLES(2), .LOAD_BUBBLES(1),
    .DRAIN_CYCLES(3), .CNT_WIDTH(4)
  ) dut (
    .hz_clk(clk), .hz_rst(rst_n), .hz_i_start(start), .hz_i_halt(halt),
    .hz_i_change_pc(cpc), .hz_i_next_pc(npc), .hz_i_stall_alu(salu),
    .hz_i_ds_valid(dsv), .hz_i_ds_is_load(dld), .hz_i_ds_addr_rd(rd),
    .hz_i_fi_addr_rs1(rs1), .hz_i_fi_addr_rs2(rs2), .hz_i_fi_uses_rs2(u2),
    .hz_o_ce(ce), .hz_o_stall(stall), .hz_o_flush(flush), .hz_o_pc_load(pcl),
    .hz_o_pc(pc), .hz_o_state(st), .hz_o_bubble_cnt(bub)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ce/stall/flush per state, straight from the state table
  function automatic logic [2:0] csf(input logic [2:0] s);
    case (s)
      3'd1:    return 3'b100;
      3'd2:    return 3'b110;
      3'd3:    return 3'b110;
      3'd4:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // monitor: one expected entry per rising edge while the scoreboard holds any
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", {29'd0, st}, {29'd0, e.st});
      chk("ce_stall_flush", {29'd0, ce, stall, flush}, {29'd0, csf(e.st)});
      chk("pc_load", {31'd0, pcl}, {31'd0, e.pcl});
      chk("pc", pc, e.pc);
      chk("bubble_cnt", {28'd0, bub}, {28'd0, e.bub});
    end
  end

  task automatic clr();
    start = 1'b0; halt = 1'b0; cpc = 1'b0; salu = 1'b0; npc = 32'd0;
    dsv = 1'b0; dld = 1'b0; u2 = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  task automatic tick(input logic [2:0] s, input logic p, input logic [31:0] a, input logic [3:0] b);
    q.push_back('{s, p, a, b});
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, {29'd0, st}, 32'd0);
    chk({tag, "_outs"}, {28'd0, ce, stall, flush, pcl}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_bub"}, {28'd0, bub}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    #3 check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    tick(3'd0, 1'b0, 32'd0, 4'd0);                      // idle holds
    cpc = 1'b1; npc = 32'h99;
    tick(3'd0, 1'b0, 32'd0, 4'd0);                      // redirect ignored in IDLE
    clr(); start = 1'b1;
    tick(3'd1, 1'b0, 32'd0, 4'd0);                      // start -> RUN
    clr(); cpc = 1'b1; npc = 32'h40;
    tick(3'd4, 1'b1, 32'h40, 4'd0);                     // redirect -> FLUSH + pc_load
    clr();
    tick(3'd4, 1'b0, 32'h40, 4'd1);
    tick(3'd1, 1'b0, 32'h40, 4'd2);                     // back to RUN after 2 flush cycles

    dsv = 1'b1; dld = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; u2 = 1'b1;
    tick(3'd2, 1'b0, 32'h40, 4'd2);                     // rs2 load-use -> one stall
    clr();
    tick(3'd1, 1'b0, 32'h40, 4'd3);
    dsv = 1'b1; dld = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; u2 = 1'b1;
    tick(3'd1, 1'b0, 32'h40, 4'd3);                     // rd=0 never hazards
    dsv = 1'b1; dld = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; u2 = 1'b0;
    tick(3'd1, 1'b0, 32'h40, 4'd3);                     // rs2 unused -> no stall
    rs1 = 5'd5;
    tick(3'd2, 1'b0, 32'h40, 4'd3);                     // rs1 match stalls
    clr();
    tick(3'd1, 1'b0, 32'h40, 4'd4);

    salu = 1'b1; cpc = 1'b1; npc = 32'h80;
    tick(3'd3, 1'b0, 32'h40, 4'd4);                     // ALU busy wins over redirect
    tick(3'd3, 1'b0, 32'h40, 4'd5);
    tick(3'd3, 1'b0, 32'h40, 4'd6);
    tick(3'd3, 1'b0, 32'h40, 4'd7);
    clr();
    tick(3'd1, 1'b0, 32'h40, 4'd8);

    cpc = 1'b1; npc = 32'h100;
    tick(3'd4, 1'b1, 32'h100, 4'd8);
    npc = 32'h200;
    tick(3'd4, 1'b1, 32'h200, 4'd9);                    // redirect during FLUSH restarts
    clr();
    tick(3'd4, 1'b0, 32'h200, 4'd10);
    tick(3'd1, 1'b0, 32'h200, 4'd11);

    halt = 1'b1;
    tick(3'd5, 1'b0, 32'h200, 4'd11);                   // halt -> DRAIN
    cpc = 1'b1; salu = 1'b1; npc = 32'h300;
    tick(3'd5, 1'b0, 32'h200, 4'd11);                   // ignored while draining
    clr();
    tick(3'd5, 1'b0, 32'h200, 4'd11);
    tick(3'd6, 1'b0, 32'h200, 4'd11);                   // HALTED after 3 drain cycles
    tick(3'd6, 1'b0, 32'h200, 4'd11);
    start = 1'b1;
    tick(3'd1, 1'b0, 32'h200, 4'd0);                    // restart clears bubble count
    clr();

    for (int i = 1; i <= 20; i++) begin
      salu = 1'b1;
      tick(3'd3, 1'b0, 32'h200, (i - 1 > 15) ? 4'd15 : 4'(i - 1));
    end
    clr();
    tick(3'd1, 1'b0, 32'h200, 4'd15);                   // saturated, no wrap

    cpc = 1'b1; npc = 32'h300;
    tick(3'd4, 1'b1, 32'h300, 4'd15);
    clr();
    #2 rst_n = 1'b0;                                    // async reset mid-FLUSH
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(3'd0, 1'b0, 32'd0, 4'd0);                      // stays IDLE after reset

    @(posedge clk); #2;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
